// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Results are computed on the start edge and released after a fixed busy period.
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MDUEN,
  input  logic [2:0]  MDUCtrl,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [3:0] MULT_N = MULT_CYCLES[3:0];
  localparam logic [3:0] DIV_N  = DIV_CYCLES[3:0];

  logic [0:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] phi_q, phi_d;
  logic [31:0] plo_q, plo_d;

  logic op_mult, op_multu, op_div, op_divu, op_mthi, op_mtlo;

  logic [63:0] prod_s, prod_u;
  logic        div_sgn, b_zero;
  logic [31:0] ua, ub, ub_safe;
  logic [31:0] q_u, r_u, quot, rem;

  assign op_mult  = (MDUCtrl == 3'd0);
  assign op_multu = (MDUCtrl == 3'd1);
  assign op_div   = (MDUCtrl == 3'd2);
  assign op_divu  = (MDUCtrl == 3'd3);
  assign op_mthi  = (MDUCtrl == 3'd4);
  assign op_mtlo  = (MDUCtrl == 3'd5);

  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Signed divide via magnitudes so overflow and rounding are explicit.
  assign div_sgn = op_div;
  assign b_zero  = (B == 32'd0);
  assign ua      = (div_sgn && A[31]) ? (~A + 32'd1) : A;
  assign ub      = (div_sgn && B[31]) ? (~B + 32'd1) : B;
  assign ub_safe = b_zero ? 32'd1 : ub;
  assign q_u     = ua / ub_safe;
  assign r_u     = ua % ub_safe;
  assign quot    = (div_sgn && (A[31] ^ B[31])) ? (~q_u + 32'd1) : q_u;
  assign rem     = (div_sgn && A[31]) ? (~r_u + 32'd1) : r_u;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    if (state_q == IDLE) begin
      if (MDUEN) begin
        unique case (1'b1)
          op_mult: begin
            phi_d   = prod_s[63:32];
            plo_d   = prod_s[31:0];
            cnt_d   = MULT_N;
            state_d = RUN;
            busy_d  = 1'b1;
          end
          op_multu: begin
            phi_d   = prod_u[63:32];
            plo_d   = prod_u[31:0];
            cnt_d   = MULT_N;
            state_d = RUN;
            busy_d  = 1'b1;
          end
          op_div, op_divu: begin
            phi_d   = b_zero ? hi_q : rem;
            plo_d   = b_zero ? lo_q : quot;
            cnt_d   = DIV_N;
            state_d = RUN;
            busy_d  = 1'b1;
          end
          op_mthi: hi_d = A;
          op_mtlo: lo_d = A;
          default: ;
        endcase
      end
    end else begin
      if (cnt_q == 4'd1) begin
        hi_d    = phi_q;
        lo_d    = plo_q;
        busy_d  = 1'b0;
        state_d = IDLE;
        cnt_d   = 4'd0;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      phi_q   <= 32'd0;
      plo_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
    end
  end

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed self-checking bench for mdu_unit.
// Each task drives one scenario and checks against hand-computed values.
module tb_mdu_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MDUEN = 1'b0;
  logic [2:0]  MDUCtrl = 3'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_pass = 0;
  int n_total = 0;

  mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .MDUEN(MDUEN), .MDUCtrl(MDUCtrl),
    .A(A), .B(B), .Busy(Busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b);
    MDUEN = 1'b1; MDUCtrl = op; A = a; B = b;
    tick();
    MDUEN = 1'b0; A = 32'hA5A5A5A5; B = 32'h5A5A5A5A; MDUCtrl = 3'd7;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (Busy && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    n_total++;
    if ({Busy, HI, LO} !== 65'd0)
      $display("FAIL reset: Busy=%b HI=%h LO=%h want 0/0/0", Busy, HI, LO);
    else n_pass++;
  endtask

  task automatic test_mult();
    int n;
    bit early;
    start_op(3'd0, 32'hFFFFFFFF, 32'd2);
    n_total++;
    if (Busy !== 1'b1) $display("FAIL mult_busy_rise: Busy=%b want 1", Busy);
    else n_pass++;
    n = 0; early = 0;
    while (Busy && n < 40) begin
      if (HI !== 32'd0 || LO !== 32'd0) early = 1;
      tick();
      n++;
    end
    n_total++;
    if (early) $display("FAIL mult_early_commit: HI/LO changed before busy fell");
    else n_pass++;
    n_total++;
    if (n !== 5) $display("FAIL mult_cycles: got %0d want 5", n);
    else n_pass++;
    n_total++;
    if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFE)
      $display("FAIL mult_result: HI=%h LO=%h want ffffffff/fffffffe", HI, LO);
    else n_pass++;
  endtask

  task automatic test_multu();
    int n;
    start_op(3'd1, 32'hFFFFFFFF, 32'd2);
    wait_done(n);
    n_total++;
    if (n !== 5 || HI !== 32'h1 || LO !== 32'hFFFFFFFE)
      $display("FAIL multu: n=%0d HI=%h LO=%h want 5/00000001/fffffffe",
               n, HI, LO);
    else n_pass++;
  endtask

  task automatic test_div();
    int n;
    start_op(3'd2, 32'hFFFFFFF9, 32'd2);
    wait_done(n);
    n_total++;
    if (n !== 10 || HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFD)
      $display("FAIL div_neg: n=%0d HI=%h LO=%h want 10/ffffffff/fffffffd",
               n, HI, LO);
    else n_pass++;
    start_op(3'd3, 32'd7, 32'd2);
    wait_done(n);
    n_total++;
    if (n !== 10 || HI !== 32'd1 || LO !== 32'd3)
      $display("FAIL divu: n=%0d HI=%h LO=%h want 10/1/3", n, HI, LO);
    else n_pass++;
    start_op(3'd2, 32'h80000000, 32'hFFFFFFFF);
    wait_done(n);
    n_total++;
    if (n !== 10 || HI !== 32'd0 || LO !== 32'h80000000)
      $display("FAIL div_ovf: n=%0d HI=%h LO=%h want 10/0/80000000",
               n, HI, LO);
    else n_pass++;
  endtask

  task automatic test_mthi_mtlo();
    int n;
    MDUEN = 1'b1; MDUCtrl = 3'd4; A = 32'h12345678;
    tick();
    n_total++;
    if (Busy !== 1'b0 || HI !== 32'h12345678)
      $display("FAIL mthi: Busy=%b HI=%h want 0/12345678", Busy, HI);
    else n_pass++;
    MDUCtrl = 3'd5; A = 32'h9ABCDEF0;
    tick();
    MDUEN = 1'b0;
    n_total++;
    if (Busy !== 1'b0 || HI !== 32'h12345678 || LO !== 32'h9ABCDEF0)
      $display("FAIL mtlo: Busy=%b HI=%h LO=%h want 0/12345678/9abcdef0",
               Busy, HI, LO);
    else n_pass++;
    start_op(3'd6, 32'h11111111, 32'd3);
    n_total++;
    if (Busy !== 1'b0 || HI !== 32'h12345678 || LO !== 32'h9ABCDEF0)
      $display("FAIL reserved_op: Busy=%b HI=%h LO=%h want no change",
               Busy, HI, LO);
    else n_pass++;
    start_op(3'd3, 32'd55, 32'd0);
    wait_done(n);
    n_total++;
    if (n !== 10 || HI !== 32'h12345678 || LO !== 32'h9ABCDEF0)
      $display("FAIL divu_by_zero: n=%0d HI=%h LO=%h want 10/12345678/9abcdef0",
               n, HI, LO);
    else n_pass++;
  endtask

  task automatic test_ignore_in_run();
    int n;
    start_op(3'd2, 32'd100, 32'd7);
    tick(); tick();
    MDUEN = 1'b1; MDUCtrl = 3'd0; A = 32'd3; B = 32'd3;
    tick();
    MDUEN = 1'b0;
    n_total++;
    if (Busy !== 1'b1) $display("FAIL ignore_mult: Busy=%b want 1", Busy);
    else n_pass++;
    repeat (6) tick();
    MDUEN = 1'b1; MDUCtrl = 3'd4; A = 32'hDEADBEEF;
    tick();
    MDUEN = 1'b0;
    n_total++;
    if (Busy !== 1'b0 || HI !== 32'd2 || LO !== 32'd14)
      $display("FAIL ignore_commit: Busy=%b HI=%h LO=%h want 0/2/14",
               Busy, HI, LO);
    else n_pass++;
    start_op(3'd0, 32'd3, 32'd5);
    n_total++;
    if (Busy !== 1'b1) $display("FAIL b2b_accept: Busy=%b want 1", Busy);
    else n_pass++;
    wait_done(n);
    n_total++;
    if (n !== 5 || HI !== 32'd0 || LO !== 32'd15)
      $display("FAIL b2b_result: n=%0d HI=%h LO=%h want 5/0/15", n, HI, LO);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    int n;
    start_op(3'd0, 32'd5, 32'd5);
    tick(); tick();
    #2 reset = 1'b1;
    #1;
    n_total++;
    if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0)
      $display("FAIL async_reset: Busy=%b HI=%h LO=%h want 0/0/0",
               Busy, HI, LO);
    else n_pass++;
    #1 reset = 1'b0;
    tick();
    n_total++;
    if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0)
      $display("FAIL reset_no_commit: Busy=%b HI=%h LO=%h want 0/0/0",
               Busy, HI, LO);
    else n_pass++;
    start_op(3'd3, 32'd9, 32'd4);
    n_total++;
    if (Busy !== 1'b1) $display("FAIL post_reset_accept: Busy=%b want 1", Busy);
    else n_pass++;
    wait_done(n);
    n_total++;
    if (n !== 10 || HI !== 32'd1 || LO !== 32'd2)
      $display("FAIL post_reset_divu: n=%0d HI=%h LO=%h want 10/1/2",
               n, HI, LO);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_mthi_mtlo();
    test_ignore_in_run();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
